// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite register slave with per-register access modes: read/write, read-only status,
// sticky write-1-to-clear events and write-1-to-pulse strobes.
module axi4_lite_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_OF_REGISTERS   = 16,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(NUM_OF_REGISTERS*(C_S_AXI_DATA_WIDTH/8)),
  parameter logic [2*NUM_OF_REGISTERS-1:0] REG_MODE = '0
) (
  input  logic                                          S_AXI_ACLK,
  input  logic                                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
  input  logic [2:0]                                    S_AXI_AWPROT,
  input  logic                                          S_AXI_AWVALID,
  output logic                                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
  input  logic                                          S_AXI_WVALID,
  output logic                                          S_AXI_WREADY,
  output logic [1:0]                                    S_AXI_BRESP,
  output logic                                          S_AXI_BVALID,
  input  logic                                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
  input  logic [2:0]                                    S_AXI_ARPROT,
  input  logic                                          S_AXI_ARVALID,
  output logic                                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
  output logic [1:0]                                    S_AXI_RRESP,
  output logic                                          S_AXI_RVALID,
  input  logic                                          S_AXI_RREADY,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] init_val,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] status_in,
  input  logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] event_in,
  output logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] val,
  output logic [C_S_AXI_DATA_WIDTH*NUM_OF_REGISTERS-1:0] pulse,
  output logic                                          irq
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int N        = NUM_OF_REGISTERS;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW/8;
  localparam int ADDR_LSB = $clog2(SW);
  localparam int IW       = AW - ADDR_LSB;

  typedef enum logic [1:0] {MODE_RW = 2'd0, MODE_RO = 2'd1, MODE_W1C = 2'd2, MODE_W1P = 2'd3} mode_e;

  logic                   ready_en_q, ready_en_d;
  logic                   aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0]          aw_addr_q, aw_addr_d;
  logic [DW-1:0]          w_data_q, w_data_d;
  logic [SW-1:0]          w_strb_q, w_strb_d;
  logic                   bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d;
  logic                   ar_held_q, ar_held_d;
  logic [AW-1:0]          ar_addr_q, ar_addr_d;
  logic                   rvalid_q, rvalid_d;
  logic [DW-1:0]          rdata_q, rdata_d;
  logic [1:0]             rresp_q, rresp_d;
  logic [N-1:0][DW-1:0]   regs_q, regs_d, pulse_q, pulse_d;
  logic                   irq_q, irq_d;

  logic [N-1:0][DW-1:0]   init_v, status_v, event_v, val_v;
  logic                   aw_hs, w_hs, commit, wr_ok;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data, wr_mask;
  logic [SW-1:0]          wr_strb;
  logic [IW-1:0]          wr_idx;
  logic                   ar_hs, r_free, rd_req, rd_load, rd_ok;
  logic [AW-1:0]          rd_addr;
  logic [IW-1:0]          rd_idx;
  logic [DW-1:0]          rd_word;
  logic                   unused_ok;

  assign init_v   = init_val;
  assign status_v = status_in;
  assign event_v  = event_in;

  // A channel captured in an earlier cycle or handshaking now both count toward a commit.
  always_comb begin
    aw_hs   = S_AXI_AWVALID & ~aw_held_q & ready_en_q;
    w_hs    = S_AXI_WVALID & ~w_held_q & ready_en_q;
    wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
    wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
    wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
    commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & (~bvalid_q | S_AXI_BREADY);
    wr_idx  = wr_addr[AW-1:ADDR_LSB];
    wr_ok   = 32'(wr_idx) < 32'(N);
    wr_mask = '0;
    for (int b = 0; b < SW; b++) wr_mask[8*b +: 8] = {8{wr_strb[b]}};
    aw_held_d = (aw_held_q | aw_hs) & ~commit;
    w_held_d  = (w_held_q | w_hs) & ~commit;
    aw_addr_d = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
    w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
    bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
    bresp_d   = commit ? (wr_ok ? 2'b00 : 2'b10) : bresp_q;
    ready_en_d = 1'b1;
  end

  // Events are OR-ed in after the clear so a same-cycle event keeps its bit set.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    irq_d   = 1'b0;
    for (int i = 0; i < N; i++) begin
      case (REG_MODE[2*i +: 2])
        MODE_RW:  if (commit && wr_ok && wr_idx == IW'(i))
                    regs_d[i] = (regs_q[i] & ~wr_mask) | (wr_data & wr_mask);
        MODE_W1C: begin
          regs_d[i] = (regs_q[i] & ~((commit && wr_ok && wr_idx == IW'(i)) ? (wr_data & wr_mask) : '0))
                      | event_v[i];
          irq_d = irq_d | (|regs_q[i]);
        end
        MODE_W1P: if (commit && wr_ok && wr_idx == IW'(i)) pulse_d[i] = wr_data & wr_mask;
        default:  ;
      endcase
    end
  end

  always_comb begin
    ar_hs   = S_AXI_ARVALID & ~ar_held_q & ready_en_q;
    r_free  = ~rvalid_q | S_AXI_RREADY;
    rd_req  = ar_held_q | ar_hs;
    rd_load = rd_req & r_free;
    rd_addr = ar_held_q ? ar_addr_q : S_AXI_ARADDR;
    rd_idx  = rd_addr[AW-1:ADDR_LSB];
    rd_ok   = 32'(rd_idx) < 32'(N);
    rd_word = '0;
    for (int i = 0; i < N; i++) begin
      if (rd_idx == IW'(i)) begin
        case (REG_MODE[2*i +: 2])
          MODE_RW, MODE_W1C: rd_word = regs_q[i];
          MODE_RO:           rd_word = status_v[i];
          default:           rd_word = '0;
        endcase
      end
    end
    ar_held_d = rd_req & ~r_free;
    ar_addr_d = ar_hs ? S_AXI_ARADDR : ar_addr_q;
    rvalid_d  = rd_load | (rvalid_q & ~S_AXI_RREADY);
    rdata_d   = rd_load ? (rd_ok ? rd_word : '0) : rdata_q;
    rresp_d   = rd_load ? (rd_ok ? 2'b00 : 2'b10) : rresp_q;
  end

  always_comb begin
    val_v = '0;
    for (int i = 0; i < N; i++) begin
      case (REG_MODE[2*i +: 2])
        MODE_RW, MODE_W1C: val_v[i] = regs_q[i];
        MODE_RO:           val_v[i] = status_v[i];
        default:           val_v[i] = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      ar_held_q  <= 1'b0;
      ar_addr_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      regs_q     <= init_v;
      pulse_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      ar_held_q  <= ar_held_d;
      ar_addr_q  <= ar_addr_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
      pulse_q    <= pulse_d;
      irq_q      <= irq_d;
    end
  end

  assign S_AXI_AWREADY = ready_en_q & ~aw_held_q;
  assign S_AXI_WREADY  = ready_en_q & ~w_held_q;
  assign S_AXI_ARREADY = ready_en_q & ~ar_held_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign val           = val_v;
  assign pulse         = pulse_q;
  assign irq           = irq_q;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[ADDR_LSB-1:0], rd_addr[ADDR_LSB-1:0],
                       status_in, event_in, init_val, regs_q};

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: 12 registers, 6-bit address, mixed access modes.
module tb_axi4_lite_regfile;

  localparam int DW = 32;
  localparam int N  = 12;
  localparam int AW = 6;
  // reg2 RO, reg4 W1C, reg5 W1P, all others RW
  localparam logic [2*N-1:0] MODES = 24'h000E10;

  logic              clk, rst_n;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [DW*N-1:0]   init_val, status_in, event_in, val, pulse;
  logic              irq;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[14];
  logic [31:0] exp_val[N];

  axi4_lite_regfile #(
    .C_S_AXI_DATA_WIDTH(DW), .NUM_OF_REGISTERS(N), .C_S_AXI_ADDR_WIDTH(AW), .REG_MODE(MODES)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .init_val(init_val), .status_in(status_in), .event_in(event_in),
    .val(val), .pulse(pulse), .irq(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failTimeout(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: timed out waiting on DUT, got 0 expected 1", name);
  endtask

  task automatic axiWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp);
    logic aw_go, w_go;
    int t;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    t = 0;
    while ((awvalid || wvalid) && t < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge clk);
      if (aw_go) awvalid = 1'b0;
      if (w_go) wvalid = 1'b0;
      t++;
    end
    if (awvalid || wvalid) begin
      failTimeout("write_addr_data");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    t = 0;
    while (!bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bvalid) failTimeout("write_bvalid");
    resp = bresp;
    @(negedge clk);
  endtask

  task automatic axiRead(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int t;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!arready) failTimeout("read_addr");
    @(negedge clk);
    arvalid = 1'b0;
    t = 0;
    while (!rvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rvalid) failTimeout("read_rvalid");
    data = rdata;
    resp = rresp;
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [1:0]  resp;
    logic [31:0] data;
    if (v.is_wr) begin
      axiWrite(v.addr, v.data, v.strb, resp);
      checkOutput($sformatf("vec%0d_bresp", idx), 64'(resp), 64'(v.exp_resp));
    end else begin
      axiRead(v.addr, data, resp);
      checkOutput($sformatf("vec%0d_rresp", idx), 64'(resp), 64'(v.exp_resp));
      checkOutput($sformatf("vec%0d_rdata", idx), 64'(data), 64'(v.exp_rdata));
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;

    rst_n = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1; event_in = '0;
    for (int i = 0; i < N; i++) begin
      init_val[i*DW +: DW]  = 32'h0100_0000 | 32'(i);
      status_in[i*DW +: DW] = 32'hDEAD_0000 | 32'(i);
    end
    init_val[1*DW +: DW]  = 32'h1122_3344;
    init_val[4*DW +: DW]  = 32'h0;
    status_in[2*DW +: DW] = 32'h0000_005A;
    #2 rst_n = 1'b0;

    vecs[0]  = '{1'b0, 6'h00, 32'h0,         4'h0,    2'b00, 32'h0100_0000};
    vecs[1]  = '{1'b1, 6'h00, 32'hCAFE_F00D, 4'hF,    2'b00, 32'h0};
    vecs[2]  = '{1'b0, 6'h00, 32'h0,         4'h0,    2'b00, 32'hCAFE_F00D};
    vecs[3]  = '{1'b1, 6'h04, 32'h0000_AB00, 4'b0010, 2'b00, 32'h0};
    vecs[4]  = '{1'b0, 6'h04, 32'h0,         4'h0,    2'b00, 32'h1122_AB44};
    vecs[5]  = '{1'b1, 6'h08, 32'hFFFF_FFFF, 4'hF,    2'b00, 32'h0};
    vecs[6]  = '{1'b0, 6'h08, 32'h0,         4'h0,    2'b00, 32'h0000_005A};
    vecs[7]  = '{1'b1, 6'h30, 32'h1234_5678, 4'hF,    2'b10, 32'h0};
    vecs[8]  = '{1'b0, 6'h3C, 32'h0,         4'h0,    2'b10, 32'h0};
    vecs[9]  = '{1'b0, 6'h30, 32'h0,         4'h0,    2'b10, 32'h0};
    vecs[10] = '{1'b0, 6'h14, 32'h0,         4'h0,    2'b00, 32'h0};
    vecs[11] = '{1'b1, 6'h18, 32'h00FF_00FF, 4'b1001, 2'b00, 32'h0};
    vecs[12] = '{1'b0, 6'h18, 32'h0,         4'h0,    2'b00, 32'h0000_00FF};
    vecs[13] = '{1'b0, 6'h0C, 32'h0,         4'h0,    2'b00, 32'hDEAD_BEEF};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", 64'(awready), 64'd0);
    checkOutput("rst_wready", 64'(wready), 64'd0);
    checkOutput("rst_arready", 64'(arready), 64'd0);
    checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
    checkOutput("rst_rdata", 64'(rdata), 64'd0);
    checkOutput("rst_irq", 64'(irq), 64'd0);
    checkOutput("rst_val0", 64'(val[0*DW +: DW]), 64'h0100_0000);
    checkOutput("rst_val2_ro", 64'(val[2*DW +: DW]), 64'h5A);
    checkOutput("rst_pulse5", 64'(pulse[5*DW +: DW]), 64'd0);
    rst_n = 1'b1;
    checkOutput("release_awready_before_clk", 64'(awready), 64'd0);
    @(negedge clk);
    checkOutput("release_awready", 64'(awready), 64'd1);
    checkOutput("release_arready", 64'(arready), 64'd1);

    // W two cycles ahead of AW; response one cycle after the AW handshake
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    checkOutput("w_first_wready_low", 64'(wready), 64'd0);
    @(negedge clk);
    checkOutput("w_first_no_bvalid", 64'(bvalid), 64'd0);
    awaddr = 6'h0C; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("w_first_bvalid", 64'(bvalid), 64'd1);
    checkOutput("w_first_bresp", 64'(bresp), 64'd0);
    @(negedge clk);
    checkOutput("w_first_bvalid_drop", 64'(bvalid), 64'd0);
    araddr = 6'h0C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checkOutput("rd3_rvalid", 64'(rvalid), 64'd1);
    checkOutput("rd3_rdata", 64'(rdata), 64'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("rd3_rvalid_drop", 64'(rvalid), 64'd0);

    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    for (int i = 0; i < N; i++) exp_val[i] = 32'h0100_0000 | 32'(i);
    exp_val[0] = 32'hCAFE_F00D; exp_val[1] = 32'h1122_AB44; exp_val[2] = 32'h5A;
    exp_val[3] = 32'hDEAD_BEEF; exp_val[4] = 32'h0;         exp_val[5] = 32'h0;
    exp_val[6] = 32'h0000_00FF;
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("val%0d_after_table", i), 64'(val[i*DW +: DW]), 64'(exp_val[i]));

    // W1C: event sets a sticky bit, irq follows one cycle later, write-1 clears it
    event_in[4*DW + 4] = 1'b1;
    @(negedge clk);
    event_in[4*DW + 4] = 1'b0;
    checkOutput("w1c_val_set", 64'(val[4*DW +: DW]), 64'h10);
    checkOutput("w1c_irq_lag", 64'(irq), 64'd0);
    @(negedge clk);
    checkOutput("w1c_irq_set", 64'(irq), 64'd1);
    axiRead(6'h10, data, resp);
    checkOutput("w1c_rd_set", 64'(data), 64'h10);
    axiWrite(6'h10, 32'h10, 4'hF, resp);
    checkOutput("w1c_clr_bresp", 64'(resp), 64'd0);
    axiRead(6'h10, data, resp);
    checkOutput("w1c_rd_clr", 64'(data), 64'h0);
    checkOutput("w1c_irq_clr", 64'(irq), 64'd0);
    @(negedge clk);
    awaddr = 6'h10; wdata = 32'h10; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    event_in[4*DW + 4] = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; event_in[4*DW + 4] = 1'b0;
    checkOutput("w1c_race_bvalid", 64'(bvalid), 64'd1);
    axiRead(6'h10, data, resp);
    checkOutput("w1c_race_event_wins", 64'(data), 64'h10);

    // W1P: strobe visible for exactly the cycle after commit
    @(negedge clk);
    awaddr = 6'h14; wdata = 32'h81; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("w1p_pulse%0d", i), 64'(pulse[i*DW +: DW]), (i == 5) ? 64'h81 : 64'h0);
    @(negedge clk);
    checkOutput("w1p_pulse5_gone", 64'(pulse[5*DW +: DW]), 64'h0);
    axiRead(6'h14, data, resp);
    checkOutput("w1p_rd_zero", 64'(data), 64'h0);

    // B back-pressure: response held, second write captured but not committed
    bready = 1'b0;
    @(negedge clk);
    awaddr = 6'h1C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    checkOutput("bp_b_first", 64'(bvalid), 64'd1);
    awaddr = 6'h30; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      checkOutput($sformatf("bp_bvalid_c%0d", c), 64'(bvalid), 64'd1);
      checkOutput($sformatf("bp_bresp_c%0d", c), 64'(bresp), 64'd0);
    end
    checkOutput("bp_awready_held", 64'(awready), 64'd0);
    checkOutput("bp_wready_held", 64'(wready), 64'd0);
    checkOutput("bp_val7", 64'(val[7*DW +: DW]), 64'h77);
    bready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_bvalid", 64'(bvalid), 64'd1);
    checkOutput("bp_second_bresp", 64'(bresp), 64'd2);
    @(negedge clk);
    checkOutput("bp_bvalid_done", 64'(bvalid), 64'd0);

    // R back-pressure: data held, second address parked until R drains
    rready = 1'b0;
    araddr = 6'h1C; arvalid = 1'b1;
    @(negedge clk);
    araddr = 6'h3C;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      arvalid = 1'b0;
      checkOutput($sformatf("rp_rvalid_c%0d", c), 64'(rvalid), 64'd1);
      checkOutput($sformatf("rp_rdata_c%0d", c), 64'(rdata), 64'h77);
      checkOutput($sformatf("rp_rresp_c%0d", c), 64'(rresp), 64'd0);
    end
    checkOutput("rp_arready_held", 64'(arready), 64'd0);
    rready = 1'b1;
    @(negedge clk);
    checkOutput("rp_second_rvalid", 64'(rvalid), 64'd1);
    checkOutput("rp_second_rdata", 64'(rdata), 64'h0);
    checkOutput("rp_second_rresp", 64'(rresp), 64'd2);
    @(negedge clk);
    checkOutput("rp_rvalid_done", 64'(rvalid), 64'd0);

    // Reset in the middle of a pending response and a held address
    bready = 1'b0;
    awaddr = 6'h0C; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0; awaddr = 6'h00;
    checkOutput("mid_val3_written", 64'(val[3*DW +: DW]), 64'h1234_5678);
    @(negedge clk);
    awvalid = 1'b0;
    checkOutput("mid_aw_held", 64'(awready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_bvalid", 64'(bvalid), 64'd0);
    checkOutput("mid_rst_awready", 64'(awready), 64'd0);
    checkOutput("mid_rst_irq", 64'(irq), 64'd0);
    checkOutput("mid_rst_val0", 64'(val[0*DW +: DW]), 64'h0100_0000);
    checkOutput("mid_rst_val3", 64'(val[3*DW +: DW]), 64'h0100_0003);
    checkOutput("mid_rst_val4", 64'(val[4*DW +: DW]), 64'h0);
    checkOutput("mid_rst_val7", 64'(val[7*DW +: DW]), 64'h0100_0007);
    @(negedge clk);
    rst_n = 1'b1;
    bready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_awready", 64'(awready), 64'd1);
    repeat (2) @(negedge clk);
    checkOutput("post_rst_no_bvalid", 64'(bvalid), 64'd0);
    checkOutput("post_rst_val3", 64'(val[3*DW +: DW]), 64'h0100_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_lite_regfile.md
Name: axi4_lite_regfile

Overview:
- Parametrised successor to the team's single-mode AXI4-Lite register slave.
- Each register has its own access mode: read/write, read-only status, sticky write-1-to-clear event, or write-1-to-pulse.
- AW and W channels are accepted independently, and B/R back-pressure is supported.
- Out-of-range accesses return SLVERR.
- Used as the control/status block for TSN datapath modules.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
- NUM_OF_REGISTERS, 16, number of registers; need not be a power of two.
- C_S_AXI_ADDR_WIDTH, $clog2(NUM_OF_REGISTERS*(C_S_AXI_DATA_WIDTH/8)), byte address width; may be set larger.
- REG_MODE, all zeros (2*NUM_OF_REGISTERS bits), 2 bits per register, register i at [2i+1:2i]. 0=RW, 1=RO, 2=W1C, 3=W1P.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, S_AXI_WDATA/WSTRB/WVALID/WREADY, S_AXI_BRESP/BVALID/BREADY, S_AXI_ARADDR/ARPROT/ARVALID/ARREADY, S_AXI_RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite slave, widths per parameters; PROT ignored.
- init_val  in  DW*N  reset value per register (RW, W1C).
- status_in  in  DW*N  live value for RO registers; other slices unused.
- event_in  in  DW*N  per-bit set strobes for W1C registers; other slices unused.
- val  out  DW*N  RW: stored value; RO: status_in; W1C: sticky bits; W1P: 0.
- pulse  out  DW*N  one-cycle strobes for W1P registers; 0 elsewhere.
- irq  out  1  registered OR of all W1C bits.

Behaviour:
- Reset (async assert, sync release): AWREADY/WREADY/ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0, pulse=0, irq=0. RW/W1C storage=init_val. Ready outputs go to 1 on the first clock after release.
- Reset asserted mid-transaction aborts it; no response is issued.
- Address decode: word index = addr[ADDR_WIDTH-1:ADDR_LSB], where ADDR_LSB=$clog2(DW/8). Index >= NUM_OF_REGISTERS is out of range.
- Write path: aw_held and w_held holding registers.
  - AWREADY=~aw_held, WREADY=~w_held.
  - Each channel is captured on its own handshake; AW and W may arrive in either order or in the same cycle.
  - Commit occurs in the cycle where aw_held&w_held&(~BVALID|BREADY).
  - On commit: update storage, BVALID=1 next edge, both held flags clear. Back-to-back commits are allowed when BREADY stays high.
- Commit semantics, byte lanes masked by WSTRB:
  - RW: stored = WDATA.
  - RO: ignored, OKAY.
  - W1C: bit cleared where WDATA=1.
  - W1P: pulse slice = WDATA&mask for exactly one cycle, the cycle after commit.
  - Out of range: no effect, BRESP=2'b10.
- W1C update each cycle: new = (old & ~clr) | event_in. An event on the same bit in the same cycle as a clear wins (bit stays 1).
- irq is registered one cycle after a sticky bit changes.
- Read path: one outstanding read.
  - ARREADY=~ar_held.
  - AR handshake in cycle N: if R is free (~RVALID, or RVALID&RREADY in N), RDATA/RRESP load and RVALID=1 at N+1. Otherwise the address is held and ARREADY stays 0 until R drains.
  - RDATA values: RW/W1C = storage; RO = status_in sampled at load; W1P = 0; out of range = 0 with RRESP=2'b10.
- Simultaneous read and write to the same register: the read returns the pre-commit value if loaded in the same cycle as the commit.
- RDATA, RRESP, BRESP are held stable while their VALID is high and READY is low.

Test Plan:
- RW write 0xDEADBEEF to reg 3 with W issued 2 cycles before AW -> BVALID one cycle after AW handshake, BRESP=0; read reg 3 -> RDATA=0xDEADBEEF, RVALID 1 cycle after AR handshake.
- Partial strobe: WSTRB=4'b0010, WDATA=0x0000AB00 to RW reg holding 0x11223344 -> reads 0x1122AB44; RO reg with status_in=0x5A -> write ignored, read 0x5A.
- W1C: event_in bit 4 pulsed -> reg reads 0x10, irq=1; write 0x10 -> reads 0, irq=0. Write 0x10 in the same cycle as event_in bit 4 -> stays 0x10.
- W1P: write 0x81 -> pulse slice = 0x81 for exactly one cycle, then 0; read returns 0.
- NUM_OF_REGISTERS=12, ADDR_WIDTH=6: write to 0x30 -> BRESP=2'b10 with no register changed; read from 0x3C -> RRESP=2'b10, RDATA=0.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable, second AW/AR not accepted. Reset pulsed mid-write -> VALIDs 0, registers = init_val.
